// File: rtl/apb_reg_slave.sv
// APB register slave: four RW data registers, a write counter and an ID word,
// served through a registered IDLE/SETUP/WAIT/ACCESS state machine with configurable wait states.
module apb_reg_slave #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0016
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [7:0]  paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [31:0] reg0_o,
    output logic [31:0] reg1_o,
    output logic [31:0] reg2_o,
    output logic [31:0] reg3_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACCESS = 2'd3
    } state_e;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 32'd0) ? 4'd0 : 4'(WAIT_CYCLES - 32'd1);

    // Misaligned, unmapped, or a write aimed at a read-only word.
    function automatic logic addr_error(input logic wr, input logic [7:0] a);
        return (a[1:0] != 2'b00) || (a > 8'h14) || (wr && (a >= 8'h10));
    endfunction

    function automatic logic [31:0] strobe_merge(input logic [31:0] old_v,
                                                 input logic [31:0] new_v,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] regs_q [4];
    logic [31:0] regs_d [4];
    logic [7:0]  wr_count_q, wr_count_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [31:0] prdata_q, prdata_d;

    logic        err_s;
    logic [31:0] rd_s;
    logic        capture_s;
    logic        go_access_s;

    assign err_s = addr_error(wr_q, addr_q);

    // Read mux over the captured address, using contents before any commit this cycle.
    always_comb begin
        rd_s = 32'h0000_0000;
        case (addr_q)
            8'h00:   rd_s = regs_q[0];
            8'h04:   rd_s = regs_q[1];
            8'h08:   rd_s = regs_q[2];
            8'h0C:   rd_s = regs_q[3];
            8'h10:   rd_s = {24'h00_0000, wr_count_q};
            8'h14:   rd_s = ID_VALUE;
            default: rd_s = 32'h0000_0000;
        endcase
    end

    // Next-state, wait counting, write commit and response generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        regs_d      = regs_q;
        wr_count_d  = wr_count_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        prdata_d    = 32'h0000_0000;
        capture_s   = 1'b0;
        go_access_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    capture_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (WAIT_CYCLES == 32'd0) begin
                    go_access_s = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (penable) begin
                    if (cnt_q == 4'd0) begin
                        go_access_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ACCESS: begin
                if (wr_q && !err_s) begin
                    regs_d[addr_q[3:2]] = strobe_merge(regs_q[addr_q[3:2]], wdata_q, strb_q);
                    wr_count_d          = wr_count_q + 8'd1;
                end else begin
                    wr_count_d = wr_count_q;
                end
                // A setup phase seen at the completing edge starts the next transfer without an idle cycle.
                if (psel && !penable) begin
                    capture_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (capture_s) begin
            state_d = ST_SETUP;
            cnt_d   = 4'd0;
            addr_d  = paddr;
            wr_d    = pwrite;
            wdata_d = pwdata;
            strb_d  = pstrb;
        end else begin
            addr_d = addr_d;
        end

        if (go_access_s) begin
            state_d   = ST_ACCESS;
            cnt_d     = 4'd0;
            pready_d  = 1'b1;
            pslverr_d = err_s;
            prdata_d  = (!wr_q && !err_s) ? rd_s : 32'h0000_0000;
        end else begin
            pready_d = 1'b0;
        end
    end

    // State, captured request, registers and registered bus responses.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 8'h00;
            wr_q       <= 1'b0;
            wdata_q    <= 32'h0000_0000;
            strb_q     <= 4'h0;
            regs_q[0]  <= 32'h0000_0000;
            regs_q[1]  <= 32'h0000_0000;
            regs_q[2]  <= 32'h0000_0000;
            regs_q[3]  <= 32'h0000_0000;
            wr_count_q <= 8'h00;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign reg0_o  = regs_q[0];
    assign reg1_o  = regs_q[1];
    assign reg2_o  = regs_q[2];
    assign reg3_o  = regs_q[3];

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench: one slave with WAIT_CYCLES=0 and one with WAIT_CYCLES=1 on a shared bus,
// directed cases plus randomized transfers checked against an array-based register model.
module tb_apb_reg_slave;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    int          sel_inst;

    logic        psel0_s, psel1_s;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;
    logic [31:0] rg0 [4];
    logic [31:0] rg1 [4];

    logic [31:0] prdata_m;
    logic        pready_m, pslverr_m;
    logic [31:0] cur_reg [4];

    logic [31:0] m_regs [2][4];
    logic [7:0]  m_wc [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rdy_cyc = 0;

    assign psel0_s = psel && (sel_inst == 0);
    assign psel1_s = psel && (sel_inst == 1);

    apb_reg_slave #(.WAIT_CYCLES(0)) u_dut0 (
        .pclk(pclk), .preset(preset), .psel(psel0_s), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0), .pready(pready0),
        .pslverr(pslverr0), .reg0_o(rg0[0]), .reg1_o(rg0[1]), .reg2_o(rg0[2]), .reg3_o(rg0[3])
    );

    apb_reg_slave #(.WAIT_CYCLES(1)) u_dut1 (
        .pclk(pclk), .preset(preset), .psel(psel1_s), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata1), .pready(pready1),
        .pslverr(pslverr1), .reg0_o(rg1[0]), .reg1_o(rg1[1]), .reg2_o(rg1[2]), .reg3_o(rg1[3])
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    always_comb begin
        prdata_m  = (sel_inst == 1) ? prdata1 : prdata0;
        pready_m  = (sel_inst == 1) ? pready1 : pready0;
        pslverr_m = (sel_inst == 1) ? pslverr1 : pslverr0;
        for (int i = 0; i < 4; i++) begin
            cur_reg[i] = (sel_inst == 1) ? rg1[i] : rg0[i];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (inst %0d, cycle %0d): got %08h, expected %08h", tag, sel_inst, cyc, obs, exp);
        end
    endtask

    function automatic int wait_of(input int s);
        return (s == 1) ? 1 : 0;
    endfunction

    function automatic logic exp_err(input logic wr, input logic [7:0] a);
        if (a % 8'd4 != 8'd0) return 1'b1;
        if (a > 8'h14) return 1'b1;
        if (wr && (a == 8'h10 || a == 8'h14)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [7:0] a);
        if (a < 8'h10) return m_regs[sel_inst][a / 8'd4];
        if (a == 8'h10) return {24'h00_0000, m_wc[sel_inst]};
        return 32'hA5B0_0016;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_wc[s] = 8'h00;
            for (int i = 0; i < 4; i++) m_regs[s][i] = 32'h0000_0000;
        end
    endtask

    // Starts at a negedge with the setup phase; returns at the negedge of the completing cycle.
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd);
        int          cnt;
        logic        e;
        logic [31:0] er;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(negedge pclk);
        penable = 1'b1;
        cnt = 0;
        while (pready_m !== 1'b1 && cnt < 20) begin
            @(negedge pclk);
            cnt++;
        end
        check_val("latency", cnt, wait_of(sel_inst) + 1);
        rdy_cyc = cyc;
        e  = exp_err(wr, a);
        er = (wr || e) ? 32'h0000_0000 : exp_read(a);
        check_val("pslverr", {31'h0, pslverr_m}, {31'h0, e});
        check_val("prdata", prdata_m, er);
        rd = prdata_m;
        if (wr && !e) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) m_regs[sel_inst][a / 8'd4][8*b +: 8] = d[8*b +: 8];
            end
            m_wc[sel_inst] = m_wc[sel_inst] + 8'd1;
        end
    endtask

    task automatic idle();
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check_val("pready_one_cycle", {31'h0, pready_m}, 32'h0);
        for (int i = 0; i < 4; i++) check_val("reg_out", cur_reg[i], m_regs[sel_inst][i]);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  a;
        int          prev;

        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 32'h0; pstrb = 4'h0; sel_inst = 1;
        model_reset();
        repeat (3) @(negedge pclk);
        for (int s = 0; s < 2; s++) begin
            sel_inst = s;
            #1;
            check_val("rst_pready", {31'h0, pready_m}, 32'h0);
            check_val("rst_pslverr", {31'h0, pslverr_m}, 32'h0);
            check_val("rst_prdata", prdata_m, 32'h0);
            for (int i = 0; i < 4; i++) check_val("rst_reg", cur_reg[i], 32'h0);
        end
        @(negedge pclk);
        preset = 1'b0;
        sel_inst = 1;

        // Basic write then STATUS read; setup is driven at the same time reset releases.
        xfer(1'b1, 8'h04, 32'h1234_ABCD, 4'hF, rd);
        idle();
        check_val("reg1_basic", cur_reg[1], 32'h1234_ABCD);
        xfer(1'b0, 8'h10, 32'h0, 4'h0, rd);
        check_val("status_one", rd, 32'h0000_0001);
        idle();

        // Byte strobes.
        xfer(1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF, rd);
        xfer(1'b1, 8'h00, 32'h0000_0000, 4'b0101, rd);
        idle();
        check_val("reg0_strb", cur_reg[0], 32'hFF00_FF00);
        xfer(1'b0, 8'h00, 32'h0, 4'h0, rd);
        check_val("reg0_strb_rd", rd, 32'hFF00_FF00);
        idle();

        // Error cases, then ID and STATUS unaffected.
        xfer(1'b1, 8'h14, 32'hDEAD_BEEF, 4'hF, rd);
        xfer(1'b0, 8'h18, 32'h0, 4'h0, rd);
        xfer(1'b0, 8'h02, 32'h0, 4'h0, rd);
        xfer(1'b1, 8'h10, 32'h0000_0055, 4'hF, rd);
        xfer(1'b0, 8'h14, 32'h0, 4'h0, rd);
        check_val("id_value", rd, 32'hA5B0_0016);
        xfer(1'b0, 8'h10, 32'h0, 4'h0, rd);
        check_val("status_after_err", rd, 32'h0000_0003);
        idle();

        // Zero-strobe write still counts.
        xfer(1'b1, 8'h0C, 32'h7777_7777, 4'h0, rd);
        idle();
        check_val("reg3_nostrb", cur_reg[3], 32'h0);

        // Abort during WAIT.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        check_val("abort_wait_pready", {31'h0, pready_m}, 32'h0);
        psel = 1'b0; penable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            check_val("abort_pready", {31'h0, pready_m}, 32'h0);
        end
        check_val("abort_reg2", cur_reg[2], m_regs[1][2]);
        xfer(1'b0, 8'h10, 32'h0, 4'h0, rd);
        idle();

        // penable without a setup phase is ignored.
        psel = 1'b1; penable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            check_val("stray_penable", {31'h0, pready_m}, 32'h0);
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);

        // Randomized traffic on both slaves with random back-to-back chaining.
        for (int s = 0; s < 2; s++) begin
            sel_inst = s;
            for (int n = 0; n < 150; n++) begin
                a = 8'($urandom_range(0, 31));
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                if ($urandom_range(0, 15) == 0) a = 8'($urandom);
                xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd);
                if ($urandom_range(0, 2) == 0) idle();
            end
            idle();
        end

        // Asynchronous reset between edges while in WAIT.
        sel_inst = 1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h1111_2222; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        #2;
        preset = 1'b1;
        #1;
        model_reset();
        check_val("async_rst_pready", {31'h0, pready_m}, 32'h0);
        for (int i = 0; i < 4; i++) check_val("async_rst_reg", cur_reg[i], 32'h0);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        preset = 1'b0;
        xfer(1'b1, 8'h0C, 32'h1111_2222, 4'hF, rd);
        idle();
        check_val("post_rst_reg3", cur_reg[3], 32'h1111_2222);
        xfer(1'b0, 8'h10, 32'h0, 4'h0, rd);
        idle();

        // wr_count wrap after 256 writes on the zero-wait slave.
        sel_inst = 0;
        for (int n = 0; n < 256; n++) begin
            xfer(1'b1, 8'(4 * (n % 4)), $urandom, 4'($urandom_range(0, 15)), rd);
        end
        xfer(1'b0, 8'h10, 32'h0, 4'h0, rd);
        check_val("status_wrap", rd, 32'h0000_0000);
        idle();

        // Back-to-back reads: one completion every second cycle.
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            xfer(1'b0, 8'(4 * k), 32'h0, 4'h0, rd);
            if (k > 0) check_val("b2b_gap", rdy_cyc - prev, 32'd2);
            prev = rdy_cyc;
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: wait states inserted in every access phase before PREADY is asserted (range 0..15).
REQ-002 Parameter ID_VALUE, default 32'hA5B0_0016: constant returned by the ID register.
REQ-003 pclk  input  1  clock; all state updates on the rising edge.
REQ-004 preset  input  1  reset, asynchronous and active-high.
REQ-005 psel  input  1  slave select from the APB requester.
REQ-006 penable  input  1  access-phase indicator.
REQ-007 pwrite  input  1  1 = write, 0 = read.
REQ-008 paddr  input  8  byte address.
REQ-009 pwdata  input  32  write data.
REQ-010 pstrb  input  4  byte write strobes; pstrb[i] enables pwdata[8i+7:8i].
REQ-011 prdata  output  32  read data.
REQ-012 pready  output  1  transfer-complete indication.
REQ-013 pslverr  output  1  transfer error; meaningful only while pready=1.
REQ-014 reg0_o..reg3_o  output  32 each  current contents of REG0..REG3.

Function
REQ-015 Address map: 0x00..0x0C hold REG0..REG3 (RW); 0x10 holds STATUS (RO) = {24'h0, wr_count[7:0]}; 0x14 holds ID (RO) = ID_VALUE.
REQ-016 FSM states: IDLE, SETUP, WAIT, ACCESS; all registered.
REQ-017 IDLE -> SETUP when psel=1 and penable=0 are sampled at a clock edge; paddr, pwrite, pwdata and pstrb are captured at that edge.
REQ-018 SETUP -> ACCESS when WAIT_CYCLES=0; otherwise SETUP -> WAIT, with the wait counter loaded with WAIT_CYCLES-1.
REQ-019 WAIT: counter decrements each cycle while psel=1 and penable=1; WAIT -> ACCESS after exactly WAIT_CYCLES cycles.
REQ-020 pready=1 only in ACCESS; pready=0 in IDLE, SETUP and WAIT. Access-phase length = WAIT_CYCLES+1 cycles.
REQ-021 ACCESS lasts one cycle; it returns to IDLE, or goes directly to SETUP if the next setup phase is sampled at the same edge (back-to-back transfers).
REQ-022 psel=0 sampled in SETUP or WAIT aborts the transfer: go to IDLE, no register write, no wr_count change, pready and pslverr stay 0.
REQ-023 penable=1 sampled in IDLE with no preceding setup phase is ignored: stay in IDLE, pready=0.
REQ-024 Error condition (pslverr=1 in ACCESS): paddr[1:0]!=0, or paddr>0x14, or a write to STATUS or ID.
REQ-025 An erroring write changes no state and does not increment wr_count; an erroring read returns prdata=0.
REQ-026 A valid write to REG0..REG3 commits at the ACCESS clock edge; each byte is updated only where pstrb=1.
REQ-027 pstrb=4'b0000 on a valid write is legal: no bytes change, and wr_count still increments.
REQ-028 wr_count increments by 1 per successful write, including pstrb=0, and wraps 0xFF -> 0x00.
REQ-029 prdata carries the addressed register only while pready=1 and pwrite=0 and no error; otherwise prdata=0.
REQ-030 The read value reflects register contents before any write committing in the same cycle.
REQ-031 reg0_o..reg3_o are direct register outputs and update the cycle after a write commits.

Reset
REQ-032 preset=1 immediately forces, independent of pclk: state=IDLE, REG0..REG3=0, wr_count=0, counter=0, pready=0, pslverr=0, prdata=0.
REQ-033 preset asserted mid-transfer, in any state, abandons the transfer with no register update.
REQ-034 After preset deasserts, the first setup phase is accepted on the next rising edge.

Verification
REQ-035 WAIT_CYCLES=1, write 0x1234ABCD to 0x04 with pstrb=F -> pready high in the 2nd access cycle, pslverr=0, reg1_o=0x1234ABCD, then read 0x10 -> prdata=0x00000001.
REQ-036 REG0=0xFFFFFFFF, write 0x00000000 to 0x00 with pstrb=4'b0101 -> reg0_o=0xFF00FF00; read 0x00 -> 0xFF00FF00.
REQ-037 Write to 0x14, read 0x18, read 0x02 -> each gets pslverr=1 with pready; prdata=0; ID and wr_count unchanged; a following read of 0x14 -> 0xA5B00016.
REQ-038 Drop psel during WAIT of a write to 0x08 -> no pready, reg2_o unchanged, wr_count unchanged, FSM IDLE; the next transfer completes normally.
REQ-039 256 successful writes -> STATUS reads 0x00 (wrap); WAIT_CYCLES=0 back-to-back reads -> pready high every second cycle with no idle gap.
REQ-040 Assert preset asynchronously (between edges) during WAIT -> outputs clear before the next edge, REG*=0, and a subsequent write after release succeeds.
